// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI minion and its pin synchronizers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

  // Frame state: IDLE while cs is high, ACTIVE while a frame is in progress.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Metastability flops per pin before the edge-detect flop.
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_minion_if.sv
// On-chip val/rdy channels of the SPI minion: recv (word to transmit) and send (word received).
// Latency: n/a (wires only).
// Backpressure: recv_rdy / send_rdy carry the usual val/rdy handshake.
interface spi_minion_if
  import spi_pkg::*;
#(
  parameter int nbits = 8
);

  logic [nbits-1:0] recv_msg;
  logic             recv_val;
  logic             recv_rdy;
  logic [nbits-1:0] send_msg;
  logic             send_val;
  logic             send_rdy;

  // Minion side: consumes recv words, produces send words.
  modport slave (
    input  recv_msg,
    input  recv_val,
    output recv_rdy,
    output send_msg,
    output send_val,
    input  send_rdy
  );

  // On-chip client side: produces recv words, consumes send words.
  modport master (
    output recv_msg,
    output recv_val,
    input  recv_rdy,
    input  send_msg,
    input  send_val,
    output send_rdy
  );

endinterface

// File: rtl/spi_minion_sync.sv
// Pin synchronizer: SYNC_STAGES metastability flops plus one edge-detect flop.
// Latency: sync/rise/fall reflect a pin change after SYNC_STAGES clk edges.
// Backpressure: none.
module spi_minion_sync
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] meta_q;
  logic [SYNC_STAGES-1:0] meta_d;
  logic                   edge_q;
  logic                   edge_d;

  // Shift the raw pin into the chain; the edge flop remembers the last synced value.
  always_comb begin
    meta_d = {meta_q[SYNC_STAGES-2:0], din};
    edge_d = meta_q[SYNC_STAGES-1];
  end

  // Reset to the pin's idle level so no edge is reported out of reset
  // unless the pin is actually away from idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= {SYNC_STAGES{RESET_VAL}};
      edge_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      edge_q <= edge_d;
    end
  end

  assign sync = meta_q[SYNC_STAGES-1];
  assign rise = sync & ~edge_q;
  assign fall = ~sync & edge_q;

endmodule

// File: rtl/spi_minion.sv
// SPI mode-0 minion: oversampled pins, deserialised frames out on send, one-word tx buffer in on recv.
// Latency: send_val 3 clk after cs rises at the pin; miso bit 3 clk after cs/sclk falls at the pin.
// Backpressure: a complete frame arriving while send is stalled is dropped and flagged on overflow.
module spi_minion
  import spi_pkg::*;
#(
  parameter int nbits = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic        overflow,
  spi_minion_if.slave bus
);

  // Counter must reach nbits+1 so long frames stay distinguishable from exact ones.
  localparam int               CNT_W    = $clog2(nbits + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(nbits);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(nbits + 1);

  // Synchronized pins and their edges.
  logic cs_s;
  logic cs_rise;
  logic cs_fall;
  logic sclk_s;
  logic sclk_rise;
  logic sclk_fall;
  logic mosi_s;
  logic mosi_rise;
  logic mosi_fall;

  spi_minion_sync #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk  (clk),
    .reset(reset),
    .din  (cs),
    .sync (cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_minion_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk  (clk),
    .reset(reset),
    .din  (sclk),
    .sync (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_minion_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk  (clk),
    .reset(reset),
    .din  (mosi),
    .sync (mosi_s),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  // Only the edges of cs/sclk and the level of mosi drive the protocol.
  logic unused_sync;
  assign unused_sync = ^{cs_s, sclk_s, mosi_rise, mosi_fall};

  // Architectural state.
  state_e           state_q,    state_d;
  logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [nbits-1:0] rx_shift_q, rx_shift_d;
  logic [nbits-1:0] tx_shift_q, tx_shift_d;
  logic [nbits-1:0] tx_buf_q,   tx_buf_d;
  logic             tx_full_q,  tx_full_d;
  logic [nbits-1:0] send_msg_q, send_msg_d;
  logic             send_val_q, send_val_d;
  logic             miso_q,     miso_d;
  logic             overflow_q, overflow_d;

  // Word loaded into the tx shifter at frame start: buffered word, or zeros if none.
  logic [nbits-1:0] load_word;
  logic             recv_fire;
  logic             send_fire;
  logic             frame_ok;

  assign load_word = tx_full_q ? tx_buf_q : '0;
  assign recv_fire = bus.recv_val & ~tx_full_q;
  assign send_fire = send_val_q & bus.send_rdy;
  assign frame_ok  = (bit_cnt_q == CNT_FULL);

  // Next-state logic: frame FSM, shifters, tx buffer fill/drain and send register.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    send_msg_d = send_msg_q;
    send_val_d = send_val_q;
    miso_d     = miso_q;
    overflow_d = 1'b0;

    // Consumer taking the current word frees the send register.
    if (send_fire) begin
      send_val_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // miso is parked low between frames; sclk activity here is ignored.
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d    = ACTIVE;
          tx_shift_d = load_word;
          tx_full_d  = 1'b0;
          bit_cnt_d  = '0;
          miso_d     = load_word[nbits-1];
        end
      end

      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
          // Only exact-length frames are delivered; short/long ones vanish quietly.
          if (frame_ok) begin
            if (!send_val_q || bus.send_rdy) begin
              send_msg_d = rx_shift_q;
              send_val_d = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[nbits-2:0], mosi_s};
            if (bit_cnt_q != CNT_SAT) begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          if (sclk_fall) begin
            tx_shift_d = {tx_shift_q[nbits-2:0], 1'b0};
            miso_d     = tx_shift_q[nbits-2];
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A recv write in the same cycle as frame start refills the buffer for the
    // next frame, so the set wins over the clear done above.
    if (recv_fire) begin
      tx_buf_d  = bus.recv_msg;
      tx_full_d = 1'b1;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      send_msg_q <= '0;
      send_val_q <= 1'b0;
      miso_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      send_msg_q <= send_msg_d;
      send_val_q <= send_val_d;
      miso_q     <= miso_d;
      overflow_q <= overflow_d;
    end
  end

  assign miso         = miso_q;
  assign overflow     = overflow_q;
  assign bus.recv_rdy = ~tx_full_q;
  assign bus.send_msg = send_msg_q;
  assign bus.send_val = send_val_q;

endmodule
